// File: rtl/frame_packer_pkg.sv
// frame_packer_pkg
//   Shared definitions for the frame packer: header tag, FIFO word width,
//   frame FSM state encoding and a popcount helper used for admission.
//   Optional feature macro (consumed by frame_packer.sv): FRAME_PACKER_CHECKSUM_EN
package frame_packer_pkg;

   localparam logic [3:0] HDR_TAG = 4'hA;
   localparam int         WORD_W  = 16;

   typedef enum logic [1:0] {IDLE, HEADER, CHAN, TRAIL} fp_state_e;

   function automatic int popcount(input logic [15:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) n += int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/frame_packer_if.sv
// frame_packer_if
//   Bundles the sample-side and host-pipe-side signals of frame_packer.
//   slave  : view used by frame_packer (samples/controls in, pipe/status out)
//   master : view used by whatever drives the packer (host / testbench)
//   Signals: sample_valid, par, ch_mask, clr_status, fifo_ren (to packer);
//            pipe_out, fifo_empty, fifo_full, fifo_level, busy, overflow,
//            drop_cnt (from packer).
interface frame_packer_if #(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic                     sample_valid;
   logic [NUM_CH*DATA_W-1:0] par;
   logic [NUM_CH-1:0]        ch_mask;
   logic                     clr_status;
   logic                     fifo_ren;
   logic [15:0]              pipe_out;
   logic                     fifo_empty;
   logic                     fifo_full;
   logic [LVL_W-1:0]         fifo_level;
   logic                     busy;
   logic                     overflow;
   logic [15:0]              drop_cnt;

   modport slave (
      input  sample_valid, par, ch_mask, clr_status, fifo_ren,
      output pipe_out, fifo_empty, fifo_full, fifo_level, busy, overflow, drop_cnt
   );

   modport master (
      output sample_valid, par, ch_mask, clr_status, fifo_ren,
      input  pipe_out, fifo_empty, fifo_full, fifo_level, busy, overflow, drop_cnt
   );
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
//   Single-clock first-word-fall-through FIFO. rd_data shows the head word
//   whenever the FIFO holds data and is forced to zero when empty.
//   Ports: ti_clk, rst_n (async low), wr_en/wr_data (write; ignored when full),
//          rd_en (pop; ignored when empty), rd_data, empty, full, level.
module sync_fifo_fwft #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1024
) (
   input  logic                     ti_clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    cnt;
   logic             do_wr, do_rd;

   assign empty = (cnt == '0);
   assign full  = (cnt == LW'(DEPTH));
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // Storage is not reset; the empty zeroing hides stale contents.
   always_ff @(posedge ti_clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + LW'(1);
            2'b01:   cnt <= cnt - LW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];
   assign level   = cnt;
endmodule

// File: rtl/frame_packer.sv
// frame_packer
//   On each accepted sample strobe, snapshots NUM_CH channel words and writes
//   a frame into an internal FWFT FIFO: header {4'hA, seq}, then each enabled
//   channel word in ascending channel order (one word per cycle, no bubbles).
//   A frame is only started if it fits entirely in the FIFO; otherwise, or if
//   a frame is already in progress, the strobe is dropped and counted.
//   Ports: ti_clk, rst_n (async low), bus (frame_packer_if.slave).
//   Optional macro FRAME_PACKER_CHECKSUM_EN: appends a trailer word holding
//   the XOR of all preceding words of the frame (header included).
module frame_packer
   import frame_packer_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024,
   parameter int SEQ_W  = 12
) (
   input  logic           ti_clk,
   input  logic           rst_n,
   frame_packer_if.slave  bus
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef FRAME_PACKER_CHECKSUM_EN
   localparam int        TRL_WORDS = 1;
   localparam fp_state_e END_ST    = TRAIL;
`else
   localparam int        TRL_WORDS = 0;
   localparam fp_state_e END_ST    = IDLE;
`endif

   fp_state_e                      state, nxt_state;
   logic [NUM_CH-1:0][DATA_W-1:0]  snap;
   logic [NUM_CH-1:0]              rem;       // channels still to be written
   logic [NUM_CH-1:0]              rem_clr;
   logic [CH_W-1:0]                cur_idx;
   logic                           last_ch;
   logic [SEQ_W-1:0]               seq;
   logic [WORD_W-1:0]              hdr_word, ch_word;
   logic [15:0]                    drop_cnt;
   logic                           overflow;
   logic [LVL_W-1:0]               level;
   logic                           wr_en, frame_end;
   logic [WORD_W-1:0]              wr_data;
   logic                           accept, drop;
   int                             frame_len, free_words;
`ifdef FRAME_PACKER_CHECKSUM_EN
   logic [WORD_W-1:0]              csum;
`endif

   // ---------------- admission ----------------
   assign frame_len  = 1 + popcount(16'(bus.ch_mask)) + TRL_WORDS;
   assign free_words = DEPTH - int'(level);
   // Pops during a frame only grow free space, so checking once at start suffices.
   assign accept     = bus.sample_valid && (state == IDLE) && (frame_len <= free_words);
   assign drop       = bus.sample_valid && !accept;

   // ---------------- channel walk ----------------
   // Lowest remaining enabled channel; disabled channels cost no cycles.
   always_comb begin
      cur_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (rem[i]) cur_idx = CH_W'(i);
   end

   always_comb begin
      rem_clr          = rem;
      rem_clr[cur_idx] = 1'b0;
      last_ch          = (rem_clr == '0);
      ch_word          = '0;
      ch_word[DATA_W-1:0] = snap[cur_idx];
   end

   assign hdr_word = {HDR_TAG, seq};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt_state;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:    if (accept) nxt_state = HEADER;
         HEADER:  nxt_state = (rem != '0) ? CHAN : END_ST;
         CHAN:    if (last_ch) nxt_state = END_ST;
         TRAIL:   nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      wr_en     = 1'b0;
      wr_data   = '0;
      frame_end = 1'b0;
      case (state)
         HEADER: begin
            wr_en     = 1'b1;
            wr_data   = hdr_word;
            frame_end = (rem == '0) && (TRL_WORDS == 0);
         end
         CHAN: begin
            wr_en     = 1'b1;
            wr_data   = ch_word;
            frame_end = last_ch && (TRL_WORDS == 0);
         end
`ifdef FRAME_PACKER_CHECKSUM_EN
         TRAIL: begin
            wr_en     = 1'b1;
            wr_data   = csum;
            frame_end = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // ---------------- frame datapath ----------------
   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         snap <= '0;
         rem  <= '0;
         seq  <= '0;
      end else begin
         if (accept) begin
            snap <= bus.par;
            rem  <= bus.ch_mask;
         end else if (state == CHAN) begin
            rem  <= rem_clr;
         end
         if (frame_end) seq <= seq + SEQ_W'(1);
      end
   end

`ifdef FRAME_PACKER_CHECKSUM_EN
   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n)                csum <= '0;
      else if (state == HEADER)  csum <= hdr_word;
      else if (state == CHAN)    csum <= csum ^ ch_word;
   end
`endif

   // ---------------- drop accounting ----------------
   // A drop in the same cycle as clr_status leaves a count of one.
   always_ff @(posedge ti_clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (bus.clr_status)            drop_cnt <= 16'd1;
         else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (bus.clr_status) begin
         drop_cnt <= '0;
         overflow <= 1'b0;
      end
   end

   // ---------------- storage ----------------
   sync_fifo_fwft #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
      .ti_clk  (ti_clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (bus.fifo_ren),
      .rd_data (bus.pipe_out),
      .empty   (bus.fifo_empty),
      .full    (bus.fifo_full),
      .level   (level)
   );

   assign bus.fifo_level = level;
   assign bus.busy       = (state != IDLE);
   assign bus.overflow   = overflow;
   assign bus.drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer
//   Scoreboard bench for frame_packer (NUM_CH=8, DATA_W=16, DEPTH=16).
//   The reference model works per frame: an accepted strobe pushes the whole
//   expected frame into a queue and records when its words land in the FIFO;
//   a separate monitor pops and compares each word the host reads.
//   Honours FRAME_PACKER_CHECKSUM_EN the same way as the design.
module tb_frame_packer;
   localparam int NUM_CH = 8;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 16;
`ifdef FRAME_PACKER_CHECKSUM_EN
   localparam int TRL = 1;
`else
   localparam int TRL = 0;
`endif

   logic ti_clk = 1'b0;
   logic rst_n  = 1'b0;

   frame_packer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   frame_packer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .SEQ_W(12)) dut (
      .ti_clk (ti_clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 ti_clk = ~ti_clk;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   // reference model state
   int cyc = 0, acc_words = 0, pops = 0, cur_t = 0, cur_L = 0;
   int m_drop = 0, m_seq = 0;
   bit m_ovf = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor: every word the host actually pops is checked against the queue
   always @(negedge ti_clk) begin
      if (rst_n && bus.fifo_ren && !bus.fifo_empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got %0h expected no word", bus.pipe_out);
         end else begin
            chk("pop_word", bus.pipe_out, exp_q.pop_front());
         end
      end
   end

   // One clock cycle: check model-visible status, drive inputs, advance model.
   task automatic step(input bit sv, input logic [7:0] m, input logic [127:0] p,
                       input bit ren, input bit clr);
      int k, lvl, len;
      bit bsy, dropped;
      logic [15:0] w, cs;
      k = cyc - cur_t - 1;
      if (k < 0) k = 0;
      if (k > cur_L) k = cur_L;
      lvl = acc_words - cur_L + k - pops;
      bsy = (cur_L > 0) && (cyc >= cur_t + 1) && (cyc <= cur_t + cur_L);
      chk("level",    bus.fifo_level, lvl);
      chk("busy",     bus.busy, bsy);
      chk("drop_cnt", bus.drop_cnt, m_drop);
      chk("overflow", bus.overflow, m_ovf);
      chk("empty",    bus.fifo_empty, lvl == 0);
      chk("full",     bus.fifo_full, lvl == DEPTH);
      if (lvl == 0) chk("pipe_out_empty", bus.pipe_out, 0);

      bus.sample_valid = sv;
      bus.ch_mask      = m;
      bus.par          = p;
      bus.fifo_ren     = ren;
      bus.clr_status   = clr;

      len     = 1 + $countones(m) + TRL;
      dropped = sv && (bsy || len > DEPTH - lvl);
      if (dropped) begin
         m_ovf  = 1;
         m_drop = clr ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
      end else if (clr) begin
         m_ovf  = 0;
         m_drop = 0;
      end
      if (sv && !dropped) begin
         w  = {4'hA, 12'(m_seq)};
         cs = w;
         exp_q.push_back(w);
         for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
               w  = p[i*16 +: 16];
               cs = cs ^ w;
               exp_q.push_back(w);
            end
         end
         if (TRL == 1) exp_q.push_back(cs);
         cur_t     = cyc;
         cur_L     = len;
         acc_words += len;
         m_seq     = (m_seq + 1) % 4096;
      end
      if (ren && lvl > 0) pops++;
      @(posedge ti_clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input bit ren);
      for (int i = 0; i < n; i++) step(0, 8'h00, '0, ren, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step(0, 8'h00, '0, 1, 0);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      idle(2, 1);
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      bus.sample_valid = 0;
      bus.ch_mask      = '0;
      bus.par          = '0;
      bus.fifo_ren     = 0;
      bus.clr_status   = 0;
      exp_q.delete();
      acc_words = 0; pops = 0; cur_t = 0; cur_L = 0;
      m_drop = 0; m_ovf = 0; m_seq = 0;
      repeat (2) @(posedge ti_clk);
      #1;
      chk("rst_pipe_out", bus.pipe_out, 0);
      chk("rst_empty",    bus.fifo_empty, 1);
      chk("rst_full",     bus.fifo_full, 0);
      chk("rst_level",    bus.fifo_level, 0);
      chk("rst_busy",     bus.busy, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_drop_cnt", bus.drop_cnt, 0);
      rst_n = 1'b1;
      idle(2, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] p, r;
      for (int i = 0; i < NUM_CH; i++) p[i*16 +: 16] = 16'h1000 + 16'(i);
      do_reset();

      // full mask: 9 words, busy 9 cycles
      step(1, 8'hFF, p, 0, 0);
      idle(10, 0);
      chk("t1_level", bus.fifo_level, 9 + TRL);
      drain();

      // sparse mask, two strobes 20 cycles apart with continuous reads
      step(1, 8'b0000_0101, p, 1, 0);
      idle(19, 1);
      step(1, 8'b0000_0101, p, 1, 0);
      idle(19, 1);
      drain();

      // empty mask: header only
      for (int i = 0; i < 3; i++) begin
         step(1, 8'h00, p, 0, 0);
         idle(3, 0);
      end
      drain();

      // admission: no reads, three full frames into a 16-word FIFO
      step(1, 8'hFF, p, 0, 0);
      idle(11, 0);
      step(1, 8'hFF, p, 0, 0);
      idle(11, 0);
      step(1, 8'hFF, p, 0, 0);
      idle(3, 0);
      chk("adm_drop_cnt", bus.drop_cnt, 2);
      chk("adm_overflow", bus.overflow, 1);
      step(0, 8'h00, '0, 0, 1);
      idle(1, 0);
      chk("clr_drop_cnt", bus.drop_cnt, 0);
      chk("clr_overflow", bus.overflow, 0);
      drain();

      // strobes on cycles 1 and 3 of a busy frame are dropped
      r = {$urandom, $urandom, $urandom, $urandom};
      step(1, 8'hFF, r, 0, 0);
      step(1, 8'hFF, p, 0, 0);
      step(0, 8'h00, '0, 0, 0);
      step(1, 8'hFF, p, 0, 0);
      idle(8, 0);
      chk("busy_drop_cnt", bus.drop_cnt, 2);
      // drop coincident with clear leaves count of one
      step(1, 8'h0F, p, 0, 0);
      step(1, 8'hFF, p, 0, 1);
      idle(6, 0);
      chk("clr_drop_same", bus.drop_cnt, 1);
      drain();
      chk("end_empty", bus.fifo_empty, 1);
      chk("end_pipe_out", bus.pipe_out, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         step(($urandom_range(0, 5) == 0), 8'($urandom), r,
              1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      end
      drain();

      // reset mid-frame discards the partial frame
      step(1, 8'hFF, p, 0, 0);
      idle(4, 0);
      do_reset();
      idle(3, 0);

      // checksum/short frame straight after reset: seq 0
      r = '0;
      r[15:0] = 16'h00FF;
      step(1, 8'h01, r, 0, 0);
      idle(4, 0);
      chk("short_level", bus.fifo_level, 2 + TRL);
      drain();

      // sequence wrap: 4097 header-only frames with continuous reads
      do_reset();
      for (int i = 0; i < 4097; i++) begin
         step(1, 8'h00, '0, 1, 0);
         step(0, 8'h00, '0, 1, 0);
      end
      drain();

      chk("final_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/frame_packer.md
Name: frame_packer

Overview:
Parametrised successor to the single-channel FIFO loader. On each sample strobe it snapshots NUM_CH parallel channel words and writes a framed burst into an internal FIFO: a header word, then each enabled channel word. The FIFO is drained by the host pipe interface in the ti_clk domain. Adds a channel-enable mask, a frame sequence number, whole-frame admission control and drop accounting.

Parameters:
NUM_CH, 8, number of parallel input channels (1..16)
DATA_W, 16, channel sample width (1..16); zero-extended to the 16-bit word
DEPTH, 1024, FIFO depth in 16-bit words; power of two, at least NUM_CH+2
SEQ_W, 12, sequence counter width; fixed at 12 because the header is 16 bits

Ports:
ti_clk  in  1  single clock for all logic
rst_n  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe: par is valid
par  in  NUM_CH*DATA_W  flattened channel data; channel i is at [i*DATA_W +: DATA_W]
ch_mask  in  NUM_CH  channel enables; sampled at frame start
clr_status  in  1  clears drop_cnt and overflow
fifo_ren  in  1  pop the head word
pipe_out  out  16  head word when not empty, else 16'd0
fifo_empty  out  1  FIFO empty
fifo_full  out  1  FIFO full
fifo_level  out  $clog2(DEPTH)+1  words currently stored
busy  out  1  frame being written
overflow  out  1  sticky: at least one frame dropped
drop_cnt  out  16  dropped-frame count; saturates at 16'hFFFF

Behaviour:
- Reset: FSM=IDLE, FIFO empty, seq=0, drop_cnt=0, overflow=0, busy=0, pipe_out=0, fifo_empty=1, fifo_full=0, fifo_level=0.
- Frame length L = 1 + popcount(ch_mask). Free space F = DEPTH - fifo_level.
- IDLE: on sample_valid, if L <= F:
  - Latch par and ch_mask into snapshot registers.
  - Go to HEADER; busy=1 the next cycle.
- IDLE: on sample_valid, if L > F: frame dropped, drop_cnt++, overflow=1, seq unchanged.
- HEADER: write {4'hA, seq}, then go to CHAN with channel index 0.
- CHAN: walk the channel index 0..NUM_CH-1; write one word per cycle for enabled channels only, in ascending order. Disabled channels are skipped with zero bubble cycles; a priority-encode of the remaining mask is acceptable.
- After the last enabled channel (or directly after HEADER if the mask is all zero): seq++ (wraps 4095 to 0), return to IDLE.
- Timing: the first word is written 1 cycle after the strobe; the last word at strobe + L.
- sample_valid while busy: frame dropped, drop_cnt++, overflow=1.
- Admission guarantees no write ever hits a full FIFO, because pops during a frame only add space.
- Read side is first-word-fall-through:
  - pipe_out is the head word and updates the cycle after a pop.
  - fifo_ren while empty is ignored; level unchanged.
  - Simultaneous write and pop: level unchanged, data order preserved.
- clr_status clears drop_cnt and overflow. If a drop occurs in the same cycle, the drop wins: drop_cnt=1, overflow=1.
- Reset asserted mid-frame aborts immediately: the FIFO is flushed and nothing partial survives.

Optional Feature:
FRAME_PACKER_CHECKSUM_EN:
- When defined, L gains +1 and a trailer word equal to the XOR of all words in the frame (header included) is written after the last channel word. Admission uses the enlarged L.
- When undefined, there is no trailer and no checksum logic.

Decomposition:
- Package frame_packer_pkg holds:
  - HDR_TAG = 4'hA and WORD_W = 16
  - State enum {IDLE, HEADER, CHAN, TRAIL}
  - popcount function
- Sub-module sync_fifo_fwft (WIDTH, DEPTH): single clock, async active-low reset, FWFT, with level/full/empty outputs and empty-output zeroing. frame_packer instantiates it once.

Test Plan:
- Reset then NUM_CH=8, mask=8'hFF, par ch i = 16'h1000+i, one strobe -> 9 words: 16'hA000, 16'h1000..16'h1007; busy for 9 cycles; seq becomes 1.
- mask=8'b0000_0101, two strobes 20 cycles apart -> frames {A000,ch0,ch2} then {A001,ch0,ch2}; no bubbles.
- mask=0 -> single word 16'hA000 per strobe.
- DEPTH=16, no reads, mask=FF, 3 strobes -> frame 1 accepted (level 9); frames 2 and 3 dropped (F=7 < 9); drop_cnt=2, overflow=1. Then clr_status -> both 0.
- Strobe on cycle 1 and cycle 3 of a busy frame -> both dropped; the first frame is intact; pop all words -> correct order, then pipe_out=0 with fifo_empty=1.
- Run 4097 frames with continuous reads -> header of frame 4097 is 16'hA000 (seq wrap). With FRAME_PACKER_CHECKSUM_EN and mask=8'h01, par ch0=16'h00FF -> trailer 16'hA0FF for seq 0.
